// File: rtl/srff_bank_driver.sv
`timescale 1ns/1ps
// Write-side controller for a bank of SR flops: drives s/r from the excitation table, reads back, retries.
// Latency: done in cycle 3 after req is accepted; each retry adds 2 cycles; err at cycle 3+2*MAX_RETRY.
// Backpressure: req is sampled only when idle; requests arriving while busy or finishing are dropped.
module srff_bank_driver #(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] r_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [CW-1:0] RETRY_MAX = CW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] tgt_r, tgt_nxt;
    logic [WIDTH-1:0] s_nxt, r_nxt;
    logic [CW-1:0]    retry_cnt, retry_nxt;

    // s/r are loaded only on the edge entering DRIVE, so they are zero in every other state
    // and can never be set together: each is gated by opposite polarity of the target bit.
    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt_r;
        retry_nxt = retry_cnt;
        s_nxt     = '0;
        r_nxt     = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    tgt_nxt   = target;
                    retry_nxt = '0;
                    s_nxt     = target & ~q_fb;
                    r_nxt     = ~target & q_fb;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: state_nxt = CHECK;
            CHECK: begin
                if (q_fb == tgt_r) begin
                    state_nxt = DONE;
                end else if (retry_cnt < RETRY_MAX) begin
                    retry_nxt = retry_cnt + CW'(1);
                    s_nxt     = tgt_r & ~q_fb;
                    r_nxt     = ~tgt_r & q_fb;
                    state_nxt = DRIVE;
                end else begin
                    state_nxt = ERR;
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tgt_r     <= '0;
            retry_cnt <= '0;
            s_out     <= '0;
            r_out     <= '0;
        end else begin
            state     <= state_nxt;
            tgt_r     <= tgt_nxt;
            retry_cnt <= retry_nxt;
            s_out     <= s_nxt;
            r_out     <= r_nxt;
        end
    end

    assign busy = (state == DRIVE) || (state == CHECK);
    assign done = (state == DONE);
    assign err  = (state == ERR);

endmodule

// File: tb/tb_srff_bank_driver.sv
`timescale 1ns/1ps
// Bench for srff_bank_driver: behavioural SR bank with stuck-at faults, directed table, corner sequences, random sweep.
module tb_srff_bank_driver;

    localparam int W  = 8;
    localparam int MR = 3;

    typedef logic [W-1:0] arr_t [MR+1];

    typedef struct {
        logic [W-1:0] q0;
        logic [W-1:0] tgt;
        logic [W-1:0] stk0;
        logic [W-1:0] stk1;
        bit           hold;
        logic [W-1:0] exp_s;
        logic [W-1:0] exp_r;
        int           exp_last;
        bit           exp_ok;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst, req;
    logic [W-1:0] target, q_fb, s_out, r_out;
    logic         busy, done, err;

    logic [W-1:0] bank_q, stk0, stk1, load_val;
    logic         load;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    srff_bank_driver #(.WIDTH(W), .MAX_RETRY(MR)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .target (target),
        .q_fb   (q_fb),
        .s_out  (s_out),
        .r_out  (r_out),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    // Negedge-sampled SR bank; stuck-at masks override whatever the flop would hold.
    always @(negedge clk) begin
        if (load) bank_q <= (load_val & ~stk0) | stk1;
        else      bank_q <= (((bank_q & ~r_out) | s_out) & ~stk0) | stk1;
    end
    assign q_fb = bank_q;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_bank(input logic [W-1:0] v, input logic [W-1:0] s0, input logic [W-1:0] s1);
        stk0     = s0;
        stk1     = s1;
        load_val = v;
        load     = 1'b1;
        @(negedge clk);
        #1 load = 1'b0;
    endtask

    // Transaction-level reference: repeat "write via excitation table, read back" until the
    // bank matches or the attempt budget (1 + MR) is spent.
    function automatic void model(input logic [W-1:0] q0, input logic [W-1:0] tgt,
                                  input logic [W-1:0] s0, input logic [W-1:0] s1,
                                  output arr_t es, output arr_t er,
                                  output int last, output bit ok);
        logic [W-1:0] q;
        q    = (q0 & ~s0) | s1;
        ok   = 1'b0;
        last = 3 + 2 * MR;
        for (int a = 0; a <= MR; a++) begin
            es[a] = '0;
            er[a] = '0;
        end
        for (int a = 0; a <= MR; a++) begin
            es[a] = tgt & ~q;
            er[a] = ~tgt & q;
            q     = (((q & ~er[a]) | es[a]) & ~s0) | s1;
            if (q == tgt) begin
                ok   = 1'b1;
                last = 2 * a + 3;
                break;
            end
        end
    endfunction

    task automatic run_txn(input logic [W-1:0] q0, input logic [W-1:0] tgt,
                           input logic [W-1:0] s0, input logic [W-1:0] s1, input bit hold,
                           input arr_t es, input arr_t er, input int last, input bit ok,
                           input string tag);
        logic [W-1:0] xs, xr;
        set_bank(q0, s0, s1);
        @(posedge clk);
        #1;
        req    = 1'b1;
        target = tgt;
        @(posedge clk);
        #1;
        req    = hold;
        target = ~tgt;
        for (int cyc = 1; cyc <= last + 1; cyc++) begin
            if (cyc == 2) req = 1'b0;
            xs = '0;
            xr = '0;
            if ((cyc % 2 == 1) && (cyc < last)) begin
                xs = es[(cyc - 1) / 2];
                xr = er[(cyc - 1) / 2];
            end
            chk($sformatf("%s c%0d s_out", tag, cyc), s_out, xs);
            chk($sformatf("%s c%0d r_out", tag, cyc), r_out, xr);
            chk($sformatf("%s c%0d s&r", tag, cyc), s_out & r_out, 8'h00);
            chk($sformatf("%s c%0d busy", tag, cyc), 8'(busy), 8'(cyc < last));
            chk($sformatf("%s c%0d done", tag, cyc), 8'(done), 8'(cyc == last && ok));
            chk($sformatf("%s c%0d err", tag, cyc), 8'(err), 8'(cyc == last && !ok));
            @(posedge clk);
            #1;
        end
        if (ok) chk({tag, " bank"}, q_fb, tgt);
    endtask

    vec_t vecs[5];

    initial begin
        arr_t es, er;
        int   last;
        bit   ok;
        logic [W-1:0] q0, tg, s0, s1;

        vecs[0] = '{q0: 8'h00, tgt: 8'hA5, stk0: 8'h00, stk1: 8'h00, hold: 1'b0,
                    exp_s: 8'hA5, exp_r: 8'h00, exp_last: 3, exp_ok: 1'b1};
        vecs[1] = '{q0: 8'hF0, tgt: 8'h3C, stk0: 8'h00, stk1: 8'h00, hold: 1'b0,
                    exp_s: 8'h0C, exp_r: 8'hC0, exp_last: 3, exp_ok: 1'b1};
        vecs[2] = '{q0: 8'h00, tgt: 8'h01, stk0: 8'h01, stk1: 8'h00, hold: 1'b0,
                    exp_s: 8'h01, exp_r: 8'h00, exp_last: 9, exp_ok: 1'b0};
        vecs[3] = '{q0: 8'h5A, tgt: 8'h5A, stk0: 8'h00, stk1: 8'h00, hold: 1'b1,
                    exp_s: 8'h00, exp_r: 8'h00, exp_last: 3, exp_ok: 1'b1};
        vecs[4] = '{q0: 8'h00, tgt: 8'h00, stk0: 8'h00, stk1: 8'h80, hold: 1'b0,
                    exp_s: 8'h00, exp_r: 8'h80, exp_last: 9, exp_ok: 1'b0};

        rst = 1'b0; req = 1'b0; target = '0; load = 1'b0;
        stk0 = '0; stk1 = '0; load_val = '0;
        #1;
        chk("reset s_out", s_out, 8'h00);
        chk("reset r_out", r_out, 8'h00);
        chk("reset busy", 8'(busy), 8'h00);
        chk("reset done", 8'(done), 8'h00);
        chk("reset err", 8'(err), 8'h00);
        set_bank(8'h00, 8'h00, 8'h00);
        @(negedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            for (int a = 0; a <= MR; a++) begin
                es[a] = vecs[i].exp_s;
                er[a] = vecs[i].exp_r;
            end
            run_txn(vecs[i].q0, vecs[i].tgt, vecs[i].stk0, vecs[i].stk1, vecs[i].hold,
                    es, er, vecs[i].exp_last, vecs[i].exp_ok, $sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of DRIVE.
        set_bank(8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #1 req = 1'b1; target = 8'h0F;
        @(posedge clk);
        #1 req = 1'b0;
        chk("rstmid pre s_out", s_out, 8'h0F);
        chk("rstmid pre busy", 8'(busy), 8'h01);
        #2 rst = 1'b0;
        #1;
        chk("rstmid s_out", s_out, 8'h00);
        chk("rstmid r_out", r_out, 8'h00);
        chk("rstmid busy", 8'(busy), 8'h00);
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid idle busy", 8'(busy), 8'h00);
        chk("rstmid idle s_out", s_out, 8'h00);
        @(posedge clk);
        #1;
        chk("rstmid idle busy2", 8'(busy), 8'h00);
        chk("rstmid idle done", 8'(done), 8'h00);

        // req held high: the second transaction starts one cycle after DONE.
        set_bank(8'h11, 8'h00, 8'h00);
        @(posedge clk);
        #1 req = 1'b1; target = 8'h22;
        @(posedge clk);
        #1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (cyc == 1) begin
                chk("hold c1 s_out", s_out, 8'h22);
                chk("hold c1 r_out", r_out, 8'h11);
            end
            if (cyc == 5) begin
                req = 1'b0;
                chk("hold c5 s_out", s_out, 8'h00);
                chk("hold c5 r_out", r_out, 8'h00);
            end
            chk($sformatf("hold c%0d busy", cyc), 8'(busy), 8'(cyc == 1 || cyc == 2 || cyc == 5 || cyc == 6));
            chk($sformatf("hold c%0d done", cyc), 8'(done), 8'(cyc == 3 || cyc == 7));
            chk($sformatf("hold c%0d err", cyc), 8'(err), 8'h00);
            @(posedge clk);
            #1;
        end

        for (int n = 0; n < 1000; n++) begin
            q0 = 8'($urandom);
            tg = 8'($urandom);
            s0 = '0;
            s1 = '0;
            if ($urandom_range(0, 1) == 1) begin
                s0 = 8'($urandom & $urandom & $urandom);
                s1 = 8'($urandom & $urandom & $urandom) & ~s0;
            end
            model(q0, tg, s0, s1, es, er, last, ok);
            run_txn(q0, tg, s0, s1, 1'($urandom_range(0, 1)), es, er, last, ok,
                    $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
